// File: rtl/result_bcd_formatter.sv
// Sequential binary-to-BCD display formatter: double-dabble one bit per clock, then
// leading-zero blanking and minus-sign placement into an 8-digit nibble word.
module result_bcd_formatter #(
  parameter int unsigned BIN_W      = 21,
  parameter logic [3:0]  BLANK_CODE = 4'hF,
  parameter logic [3:0]  MINUS_CODE = 4'hA
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             neg_in,
  output logic             busy,
  output logic             done,
  output logic [31:0]      bcd_out
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam logic [31:0] BcdReset = {{7{BLANK_CODE}}, 4'h0};

  typedef enum logic [1:0] {StIdle, StShift, StFormat, StDone} state_e;

  state_e           state_q, state_d;
  logic [BIN_W-1:0] shift_q, shift_d;
  logic [27:0]      acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [31:0]      bcd_q, bcd_d;

  logic [27:0]      adj;
  logic [BIN_W+27:0] shifted;
  logic [31:0]      fmt;
  logic [7:0]       show;
  logic             seen;
  logic             nonzero;

  // Double-dabble correction: any digit >= 5 gets +3 before the shift.
  always_comb begin
    adj = '0;
    for (int i = 0; i < 7; i++) begin
      adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5) ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
    end
    shifted = {adj, shift_q} << 1;
  end

  // Display word: digits up to the most significant nonzero one, minus sign just above it.
  always_comb begin
    fmt     = '0;
    show    = '0;
    seen    = 1'b0;
    nonzero = |acc_q;
    for (int i = 6; i >= 0; i--) begin
      if (acc_q[4*i +: 4] != 4'd0) seen = 1'b1;
      show[i] = seen || (i == 0);
    end
    for (int i = 0; i < 7; i++) begin
      fmt[4*i +: 4] = show[i] ? acc_q[4*i +: 4] : BLANK_CODE;
    end
    fmt[31:28] = BLANK_CODE;
    for (int j = 1; j < 8; j++) begin
      if (neg_q && nonzero && show[j-1] && !show[j]) fmt[4*j +: 4] = MINUS_CODE;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    bcd_d   = bcd_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shift_d = bin_in;
          neg_d   = neg_in;
          acc_d   = '0;
          cnt_d   = CntW'(BIN_W);
          state_d = StShift;
        end
      end
      StShift: begin
        acc_d   = shifted[BIN_W+27 -: 28];
        shift_d = shifted[BIN_W-1:0];
        cnt_d   = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StFormat;
      end
      StFormat: begin
        bcd_d   = fmt;
        state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      bcd_q   <= BcdReset;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy    = (state_q != StIdle);
  assign done    = (state_q == StDone);
  assign bcd_out = bcd_q;

endmodule

// File: tb/tb_result_bcd_formatter.sv
// Directed bench for result_bcd_formatter: expected words queued at start, checked on done.
module tb_result_bcd_formatter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [20:0] bin_in;
  logic        neg_in;
  logic        busy;
  logic        done;
  logic [31:0] bcd_out;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  logic [31:0] exp_q[$];

  result_bcd_formatter dut (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (start),
    .bin_in  (bin_in),
    .neg_in  (neg_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: decimal digits by division, blank above the top nonzero digit.
  function automatic logic [31:0] model(input int unsigned v, input bit neg);
    logic [31:0] r;
    logic [3:0]  d[7];
    int unsigned t;
    int          k;
    t = v;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      d[i] = 4'(t % 10);
      t    = t / 10;
      if (d[i] != 4'd0) k = i;
    end
    r = 32'hFFFFFFFF;
    for (int i = 0; i <= k; i++) r[4*i +: 4] = d[i];
    if (neg && v != 0) r[4*(k+1) +: 4] = 4'hA;
    return r;
  endfunction

  // Scoreboard: every done pulse must match a queued expectation.
  always @(negedge clock) begin
    if (done === 1'b1) begin
      done_cnt++;
      check("done_has_request", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("bcd_on_done", bcd_out, exp_q.pop_front());
    end
  end

  task automatic run_conv(input logic [20:0] b, input logic n, input logic [31:0] expv);
    int cyc;
    bit got;
    @(negedge clock);
    start  = 1'b1;
    bin_in = b;
    neg_in = n;
    exp_q.push_back(expv);
    @(posedge clock);
    #1;
    start  = 1'b0;
    bin_in = 21'($urandom);
    neg_in = ~n;
    check("busy_after_accept", 32'(busy), 32'd1);
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clock);
      cyc++;
      #1;
      if (done === 1'b1) got = 1'b1;
    end
    check("latency", 32'(cyc), 32'd22);
    @(posedge clock);
    #1;
    check("done_fall", 32'(done), 32'd0);
    check("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    int          d0;
    int          cyc;
    bit          got;
    logic [20:0] r;

    reset_n = 1'b0;
    start   = 1'b1;
    bin_in  = 21'd5;
    neg_in  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    start   = 1'b0;
    check("reset_bcd", bcd_out, 32'hFFFFFFF0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("idle_bcd_hold", bcd_out, 32'hFFFFFFF0);

    run_conv(21'd1234, 1'b0, 32'hFFFF1234);
    run_conv(21'd56, 1'b1, 32'hFFFFFA56);
    run_conv(21'd0, 1'b1, 32'hFFFFFFF0);
    run_conv(21'd2097151, 1'b0, 32'hF2097151);
    run_conv(21'd2097151, 1'b1, 32'hA2097151);
    run_conv(21'd1000000, 1'b0, 32'hF1000000);
    repeat (4) @(posedge clock);
    #1;
    check("bcd_holds_between", bcd_out, 32'hF1000000);

    // Start while busy must be ignored.
    d0 = done_cnt;
    @(negedge clock);
    start  = 1'b1;
    bin_in = 21'd777777;
    neg_in = 1'b0;
    exp_q.push_back(32'hFF777777);
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    start  = 1'b1;
    bin_in = 21'd42;
    neg_in = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clock);
      cyc++;
      #1;
      if (done === 1'b1) got = 1'b1;
    end
    check("ignored_start_done_seen", 32'(got), 32'd1);
    @(posedge clock);
    #1;
    check("single_done_pulse", 32'(done_cnt - d0), 32'd1);
    run_conv(21'd42, 1'b1, 32'hFFFFFA42);

    // Reset in the middle of SHIFT aborts without a done pulse.
    @(negedge clock);
    start  = 1'b1;
    bin_in = 21'd123456;
    neg_in = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    check("abort_bcd", bcd_out, 32'hFFFFFFF0);
    check("abort_busy", 32'(busy), 32'd0);
    d0 = done_cnt;
    repeat (30) @(posedge clock);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_conv(21'd654321, 1'b1, 32'hFA654321);

    for (int i = 0; i < 4; i++) begin
      r = 21'($urandom_range(0, 2097151));
      run_conv(r, 1'(i & 1), model(int'(r), bit'(i & 1)));
    end
    run_conv(21'd9, 1'b1, model(9, 1'b1));

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
